game_state_ctrl: RTL and testbench

//  Top-level game flow FSM (MENU/PLAY/WON/LOST), upstream of the obstacle position/time counter.

---
 rtl/game_state_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_game_state_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//   Top-level game flow FSM (MENU / PLAY / WON / LOST, plus RESPAWN when lives
//   are enabled). Sits upstream of the obstacle position/time counter: it
//   drives menuScreen/playerWon/playerLost into that stage and consumes its
//   game_time. Tracks the current level and, optionally, the remaining lives.
//   Everything runs on the game-tick clock.
//
//   Optional feature macro: GAME_LIVES_EN
//     defined   -> per-game lives with a RESPAWN pause between hits
//     undefined -> single life; lives_left tied to 1, lifeLost tied to 0
//
// Ports
//   clk         in   1   game tick clock
//   reset       in   1   synchronous, active-high reset
//   start_btn   in   1   raw start button, asynchronous to clk
//   collision   in   1   player/obstacle overlap, sampled every cycle
//   game_time   in   11  elapsed level time from the counter stage
//   menuScreen  out  1   high in MENU
//   playerWon   out  1   high in WON
//   playerLost  out  1   high in LOST (and in RESPAWN)
//   playing     out  1   high in PLAY
//   level       out  3   current level, 1..MAX_LEVEL
//   lives_left  out  2   remaining lives
//   lifeLost    out  1   high in RESPAWN
// ---------------------------------------------------------------------------
module game_state_ctrl #(
  parameter int unsigned WIN_TIME     = 2000,
  parameter int unsigned RESULT_HOLD  = 120,
  parameter int unsigned MAX_LEVEL    = 7,
  parameter int unsigned NUM_LIVES    = 3,
  parameter int unsigned RESPAWN_HOLD = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        collision,
  input  logic [10:0] game_time,
  output logic        menuScreen,
  output logic        playerWon,
  output logic        playerLost,
  output logic        playing,
  output logic [2:0]  level,
  output logic [1:0]  lives_left,
  output logic        lifeLost
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int unsigned GT_W     = 11;
  localparam int unsigned LVL_W    = 3;
  localparam int unsigned LIVES_W  = 2;
  localparam int unsigned STATE_W  = 3;
  localparam int unsigned HOLD_MAX = (RESULT_HOLD > RESPAWN_HOLD) ? RESULT_HOLD : RESPAWN_HOLD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [GT_W-1:0]   WIN_GT      = GT_W'(WIN_TIME);
  localparam logic [LVL_W-1:0]  LVL_FIRST   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_MAX     = LVL_W'(MAX_LEVEL);
  localparam logic [HOLD_W-1:0] RESULT_LAST = HOLD_W'(RESULT_HOLD - 1);

  localparam logic [2:0] ST_MENU    = 3'd0;
  localparam logic [2:0] ST_PLAY    = 3'd1;
  localparam logic [2:0] ST_WON     = 3'd2;
  localparam logic [2:0] ST_LOST    = 3'd3;
`ifdef GAME_LIVES_EN
  localparam logic [2:0] ST_RESPAWN = 3'd4;

  localparam logic [LIVES_W-1:0] LIVES_INIT   = LIVES_W'(NUM_LIVES);
  localparam logic [HOLD_W-1:0]  RESPAWN_LAST = HOLD_W'(RESPAWN_HOLD - 1);
`endif

  // -------------------------------------------------------------------------
  // Signals
  // -------------------------------------------------------------------------
  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [HOLD_W-1:0]  hold_nxt;
  logic [LVL_W-1:0]   level_nxt;

  logic [1:0]         btn_sync;
  logic               btn_prev;
  logic               start_rise;

`ifdef GAME_LIVES_EN
  logic [LIVES_W-1:0] lives_nxt;
`endif

  // -------------------------------------------------------------------------
  // Start button: two-flop synchronizer plus one-cycle rising-edge pulse.
  // A held button yields exactly one start_rise.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync <= 2'b00;
      btn_prev <= 1'b0;
    end else begin
      btn_sync <= {btn_sync[0], start_btn};
      btn_prev <= btn_sync[1];
    end
  end

  assign start_rise = btn_sync[1] & ~btn_prev;

  // -------------------------------------------------------------------------
  // State, hold counter and level registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_MENU;
      hold_cnt <= '0;
      level    <= LVL_FIRST;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      level    <= level_nxt;
    end
  end

`ifdef GAME_LIVES_EN
  // Lives register, refilled on every new game
  always_ff @(posedge clk) begin
    if (reset) begin
      lives_left <= LIVES_INIT;
    end else begin
      lives_left <= lives_nxt;
    end
  end
`else
  assign lives_left = LIVES_W'(1);
  assign lifeLost   = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic. hold_nxt defaults to zero so the counter clears on
  // every state change and only counts while a hold state is kept.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    level_nxt = level;
    hold_nxt  = '0;
`ifdef GAME_LIVES_EN
    lives_nxt = lives_left;
`endif

    case (state)
      ST_MENU: begin
        if (start_rise) begin
          state_nxt = ST_PLAY;
`ifdef GAME_LIVES_EN
          lives_nxt = LIVES_INIT;
`endif
        end
      end

      // Collision outranks a win landing on the same cycle
      ST_PLAY: begin
        if (collision) begin
`ifdef GAME_LIVES_EN
          if (lives_left > LIVES_W'(1)) begin
            state_nxt = ST_RESPAWN;
            lives_nxt = lives_left - LIVES_W'(1);
          end else begin
            state_nxt = ST_LOST;
            level_nxt = LVL_FIRST;
            lives_nxt = '0;
          end
`else
          state_nxt = ST_LOST;
          level_nxt = LVL_FIRST;
`endif
        end else if (game_time >= WIN_GT) begin
          state_nxt = ST_WON;
          level_nxt = (level >= LVL_MAX) ? LVL_MAX : level + LVL_W'(1);
        end
      end

      // Result screen: timed return to MENU, start_rise skips the wait
      ST_WON, ST_LOST: begin
        if (start_rise || (hold_cnt == RESULT_LAST)) begin
          state_nxt = ST_MENU;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end

`ifdef GAME_LIVES_EN
      // Short pause after losing a life, then straight back into play
      ST_RESPAWN: begin
        if (hold_cnt == RESPAWN_LAST) begin
          state_nxt = ST_PLAY;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
`endif

      default: begin
        state_nxt = ST_MENU;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered Moore decode of the state, one clock behind the state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      menuScreen <= 1'b1;
      playerWon  <= 1'b0;
      playerLost <= 1'b0;
      playing    <= 1'b0;
`ifdef GAME_LIVES_EN
      lifeLost   <= 1'b0;
`endif
    end else begin
      menuScreen <= (state == ST_MENU);
      playerWon  <= (state == ST_WON);
      playing    <= (state == ST_PLAY);
`ifdef GAME_LIVES_EN
      playerLost <= (state == ST_LOST) || (state == ST_RESPAWN);
      lifeLost   <= (state == ST_RESPAWN);
`else
      playerLost <= (state == ST_LOST);
`endif
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
//   Directed stimulus for game_state_ctrl. The stimulus process queues the
//   hand-computed outputs expected after a given clock edge; the monitor
//   samples on the falling edge, retires due entries and also checks the
//   one-hot output invariant on every cycle.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

  localparam logic [3:0] OH_MENU = 4'b1000;
  localparam logic [3:0] OH_WON  = 4'b0100;
  localparam logic [3:0] OH_LOST = 4'b0010;
  localparam logic [3:0] OH_PLAY = 4'b0001;
`ifdef GAME_LIVES_EN
  localparam logic [1:0] LIVES_FULL = 2'd3;
`else
  localparam logic [1:0] LIVES_FULL = 2'd1;
`endif

  typedef struct packed {
    int unsigned cyc;
    logic [3:0]  oh;     // {menuScreen, playerWon, playerLost, playing}
    logic [2:0]  lvl;
    logic [1:0]  lives;
    logic        life;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start_btn;
  logic        collision;
  logic [10:0] game_time;
  logic        menuScreen;
  logic        playerWon;
  logic        playerLost;
  logic        playing;
  logic [2:0]  level;
  logic [1:0]  lives_left;
  logic        lifeLost;

  int unsigned edge_cnt;
  int          n_chk;
  int          n_pass;
  logic        flush;
  exp_t        exp_q[$];
  string       name_q[$];

  game_state_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .collision  (collision),
    .game_time  (game_time),
    .menuScreen (menuScreen),
    .playerWon  (playerWon),
    .playerLost (playerLost),
    .playing    (playing),
    .level      (level),
    .lives_left (lives_left),
    .lifeLost   (lifeLost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, at edge %0d required completion", edge_cnt);
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Scoreboard helpers
  // -------------------------------------------------------------------------
  task automatic expect_at(input int unsigned cyc, input logic [3:0] oh, input logic [2:0] lvl,
                           input logic [1:0] lives, input logic life, input string nm);
    exp_t e;
    e.cyc   = cyc;
    e.oh    = oh;
    e.lvl   = lvl;
    e.lives = lives;
    e.life  = life;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk = n_chk + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  initial begin
    n_chk  = 0;
    n_pass = 0;
  end

  always @(negedge clk) begin : monitor
    logic [3:0] oh;
    logic       ok;
    exp_t       e;
    string      nm;
    oh = {menuScreen, playerWon, playerLost, playing};
    if (edge_cnt >= 1 && !flush) begin
      ok = (($countones(oh) == 1) && (lifeLost == 1'b0)) || ((lifeLost == 1'b1) && (oh == OH_LOST));
      chk("onehot", {7'd0, ok}, 8'd1);
    end
    while (exp_q.size() > 0 && (flush || exp_q[0].cyc <= edge_cnt)) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.cyc != edge_cnt) begin
        n_chk = n_chk + 1;
        $display("FAIL %s: sampled at edge %0d, expected at edge %0d", nm, edge_cnt, e.cyc);
      end else begin
        chk({nm, "_state"}, {4'd0, oh}, {4'd0, e.oh});
        chk({nm, "_level"}, {5'd0, level}, {5'd0, e.lvl});
        chk({nm, "_lives"}, {6'd0, lives_left}, {6'd0, e.lives});
        chk({nm, "_lifeLost"}, {7'd0, lifeLost}, {7'd0, e.life});
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers
  // -------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Press start from MENU; returns one cycle after playing rises (t+4).
  task automatic start_game(input logic [2:0] lvl, input logic [1:0] lives, input string nm);
    int unsigned t;
    t = edge_cnt;
    start_btn = 1'b1;
    expect_at(t + 3, OH_MENU, lvl, lives, 1'b0, {nm, "_lag"});
    expect_at(t + 4, OH_PLAY, lvl, lives, 1'b0, {nm, "_play"});
    step(3);
    start_btn = 1'b0;
    step(1);
  endtask

  // Full round: start, 1999 (no win), 2000 (win), full WON hold back to MENU.
  // hold=1 keeps the button pressed through PLAY and most of WON.
  task automatic win_round(input logic [2:0] cur, input logic [2:0] nxt, input logic hold);
    int unsigned t;
    t = edge_cnt;
    start_btn = 1'b1;
    expect_at(t + 3,   OH_MENU, cur, LIVES_FULL, 1'b0, "win_start_lag");
    expect_at(t + 4,   OH_PLAY, cur, LIVES_FULL, 1'b0, "win_start_play");
    expect_at(t + 6,   OH_PLAY, nxt, LIVES_FULL, 1'b0, "win_level");
    expect_at(t + 7,   OH_WON,  nxt, LIVES_FULL, 1'b0, "won");
    expect_at(t + 126, OH_WON,  nxt, LIVES_FULL, 1'b0, "won_hold_end");
    expect_at(t + 127, OH_MENU, nxt, LIVES_FULL, 1'b0, "won_to_menu");
    step(3);
    if (!hold) start_btn = 1'b0;
    step(1);
    game_time = 11'd1999;
    step(1);
    game_time = 11'd2000;
    step(1);
    game_time = 11'd0;
    if (hold) begin
      step(114);
      start_btn = 1'b0;
      step(7);
    end else begin
      step(121);
    end
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin : stim
    int unsigned t;
    flush     = 1'b0;
    reset     = 1'b1;
    start_btn = 1'b0;
    collision = 1'b0;
    game_time = 11'd0;
    step(2);
    expect_at(2, OH_MENU, 3'd1, LIVES_FULL, 1'b0, "reset");
    reset = 1'b0;
    step(2);

    // Held button: one start_rise only, no early skip out of WON
    win_round(3'd1, 3'd2, 1'b1);
    win_round(3'd2, 3'd3, 1'b0);

    // Reset in the middle of PLAY at level 3
    start_game(3'd3, LIVES_FULL, "mid_start");
    t = edge_cnt - 4;
    reset = 1'b1;
    expect_at(t + 5, OH_MENU, 3'd1, LIVES_FULL, 1'b0, "reset_mid");
    expect_at(t + 6, OH_MENU, 3'd1, LIVES_FULL, 1'b0, "reset_idle");
    step(1);
    reset = 1'b0;
    step(2);

    // Climb to level 7 and check saturation
    win_round(3'd1, 3'd2, 1'b0);
    win_round(3'd2, 3'd3, 1'b0);
    win_round(3'd3, 3'd4, 1'b0);
    win_round(3'd4, 3'd5, 1'b0);
    win_round(3'd5, 3'd6, 1'b0);
    win_round(3'd6, 3'd7, 1'b0);
    win_round(3'd7, 3'd7, 1'b0);

`ifdef GAME_LIVES_EN
    // Three hits: two respawns, then LOST with no lives left
    start_game(3'd7, 2'd3, "t5_start");
    t = edge_cnt - 4;
    collision = 1'b1;
    expect_at(t + 5,   OH_PLAY, 3'd7, 2'd2, 1'b0, "t5_hit1");
    expect_at(t + 6,   OH_LOST, 3'd7, 2'd2, 1'b1, "t5_resp1");
    expect_at(t + 35,  OH_LOST, 3'd7, 2'd2, 1'b1, "t5_resp1_end");
    expect_at(t + 36,  OH_PLAY, 3'd7, 2'd2, 1'b0, "t5_back1");
    step(1);
    collision = 1'b0;
    step(31);
    collision = 1'b1;
    expect_at(t + 37,  OH_PLAY, 3'd7, 2'd1, 1'b0, "t5_hit2");
    expect_at(t + 38,  OH_LOST, 3'd7, 2'd1, 1'b1, "t5_resp2");
    expect_at(t + 67,  OH_LOST, 3'd7, 2'd1, 1'b1, "t5_resp2_end");
    expect_at(t + 68,  OH_PLAY, 3'd7, 2'd1, 1'b0, "t5_back2");
    step(1);
    collision = 1'b0;
    step(31);
    collision = 1'b1;
    expect_at(t + 69,  OH_PLAY, 3'd1, 2'd0, 1'b0, "t5_hit3");
    expect_at(t + 70,  OH_LOST, 3'd1, 2'd0, 1'b0, "t5_lost");
    expect_at(t + 190, OH_MENU, 3'd1, 2'd0, 1'b0, "t5_menu");
    step(1);
    collision = 1'b0;
    step(122);
`else
    // Collision and win on the same cycle: LOST, then early skip on hold cycle 10
    start_game(3'd7, LIVES_FULL, "t4_start");
    t = edge_cnt - 4;
    collision = 1'b1;
    game_time = 11'd2000;
    expect_at(t + 5,  OH_PLAY, 3'd1, LIVES_FULL, 1'b0, "t4_level_clr");
    expect_at(t + 6,  OH_LOST, 3'd1, LIVES_FULL, 1'b0, "t4_lost");
    expect_at(t + 16, OH_LOST, 3'd1, LIVES_FULL, 1'b0, "t4_hold10");
    expect_at(t + 17, OH_MENU, 3'd1, LIVES_FULL, 1'b0, "t4_skip");
    expect_at(t + 19, OH_MENU, 3'd1, LIVES_FULL, 1'b0, "t4_stay");
    step(1);
    game_time = 11'd0;
    step(8);
    start_btn = 1'b1;
    collision = 1'b0;
    step(4);
    start_btn = 1'b0;
    step(3);

    // Plain collision, full LOST hold back to MENU
    start_game(3'd1, LIVES_FULL, "t6_start");
    t = edge_cnt - 4;
    collision = 1'b1;
    expect_at(t + 6,   OH_LOST, 3'd1, LIVES_FULL, 1'b0, "t6_lost");
    expect_at(t + 125, OH_LOST, 3'd1, LIVES_FULL, 1'b0, "t6_hold_end");
    expect_at(t + 126, OH_MENU, 3'd1, LIVES_FULL, 1'b0, "t6_menu");
    step(1);
    collision = 1'b0;
    step(123);
`endif

    step(3);
    flush = 1'b1;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
